// File: rtl/io_uart_tx.sv
// io_uart_tx: byte-wide UART transmitter, 8N1 by default.
// Define IO_UART_TX_PARITY_EN to add an even-parity bit (8E1).
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w_req,
  input  logic [7:0] w_data,
  output logic       w_busy,
  output logic       uart_tx,
  output logic       tx_done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

`ifdef IO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
`ifdef IO_UART_TX_PARITY_EN
  logic            par;
`endif

  // Frame sequencer: each bit lasts RELOAD+1 cycles,
  // all line/status outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      w_busy  <= 1'b0;
      tx_done <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
`ifdef IO_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (w_req) begin
            shreg   <= w_data;
            state   <= START;
            uart_tx <= 1'b0;
            w_busy  <= 1'b1;
            cnt     <= RELOAD;
`ifdef IO_UART_TX_PARITY_EN
            par     <= ^w_data;
`endif
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            cnt     <= RELOAD;
            idx     <= '0;
            uart_tx <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            cnt <= RELOAD;
            if (idx == 3'd7) begin
              idx <= '0;
`ifdef IO_UART_TX_PARITY_EN
              state   <= PARITY;
              uart_tx <= par;
`else
              state   <= STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              idx     <= idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end
        end
`ifdef IO_UART_TX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            cnt     <= RELOAD;
            state   <= STOP;
            uart_tx <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) begin
            cnt     <= cnt - ONE;
            tx_done <= (cnt == ONE);
          end else begin
            state  <= IDLE;
            w_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          w_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
